// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU core: opcodes, fetch/execute phase and widths.
package cpu_pkg;

    localparam int unsigned PC_WIDTH  = 12;
    localparam int unsigned ROM_WIDTH = 8;
    localparam int unsigned NIB_WIDTH = 4;

    localparam logic [3:0] JC    = 4'h0;
    localparam logic [3:0] JNC   = 4'h1;
    localparam logic [3:0] CMPI  = 4'h2;
    localparam logic [3:0] CMPM  = 4'h3;
    localparam logic [3:0] LIT   = 4'h4;
    localparam logic [3:0] IN    = 4'h5;
    localparam logic [3:0] LD    = 4'h6;
    localparam logic [3:0] ST    = 4'h7;
    localparam logic [3:0] JZ    = 4'h8;
    localparam logic [3:0] JNZ   = 4'h9;
    localparam logic [3:0] ADDI  = 4'hA;
    localparam logic [3:0] ADDM  = 4'hB;
    localparam logic [3:0] JMP   = 4'hC;
    localparam logic [3:0] OUT   = 4'hD;
    localparam logic [3:0] NANI  = 4'hE;
    localparam logic [3:0] NANDM = 4'hF;

    typedef enum logic {
        PHASE_FETCH = 1'b0,
        PHASE_EXEC  = 1'b1
    } phase_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load beats increment, both gated by enable, async clear.
module pc_counter #(
    parameter int unsigned WIDTH = cpu_pkg::PC_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (enable) begin
            if (load) begin
                pc_d = target;
            end else if (inc) begin
                pc_d = pc_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: PC, phase toggle, instruction register and carry/zero flags.
module fetch_sequencer #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned ROM_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [ROM_WIDTH-1:0] rom_data,
    input  logic                 IncPC,
    input  logic                 LoadPC,
    input  logic                 LoadFlags,
    input  logic                 alu_c,
    input  logic                 alu_z,
    output logic [PC_WIDTH-1:0]  rom_addr,
    output logic                 Phase,
    output logic [3:0]           Instr,
    output logic [3:0]           Oprnd,
    output logic [PC_WIDTH-1:0]  ram_addr,
    output logic                 C_flag,
    output logic                 Z_flag
);

    import cpu_pkg::*;

    phase_e               phase_q, phase_d;
    logic [NIB_WIDTH-1:0] instr_q, instr_d;
    logic [NIB_WIDTH-1:0] oprnd_q, oprnd_d;
    logic                 c_q, c_d;
    logic                 z_q, z_d;
    logic [PC_WIDTH-1:0]  target;

    // Jump target / data address: operand nibble is the high part, second byte the low part.
    assign target = PC_WIDTH'({oprnd_q, rom_data});

    pc_counter #(
        .WIDTH (PC_WIDTH)
    ) u_pc (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .load    (LoadPC),
        .inc     (IncPC),
        .target  (target),
        .pc      (rom_addr)
    );

    // Flags are only accepted in execute so a decode glitch during fetch cannot corrupt them.
    always_comb begin
        phase_d = phase_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        c_d     = c_q;
        z_d     = z_q;
        if (enable) begin
            case (phase_q)
                PHASE_FETCH: begin
                    phase_d = PHASE_EXEC;
                    instr_d = rom_data[ROM_WIDTH-1 -: NIB_WIDTH];
                    oprnd_d = rom_data[NIB_WIDTH-1:0];
                end
                PHASE_EXEC: begin
                    phase_d = PHASE_FETCH;
                    if (LoadFlags) begin
                        c_d = alu_c;
                        z_d = alu_z;
                    end
                end
                default: phase_d = PHASE_FETCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PHASE_FETCH;
            instr_q <= '0;
            oprnd_q <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            phase_q <= phase_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    assign Phase    = phase_q;
    assign Instr    = instr_q;
    assign Oprnd    = oprnd_q;
    assign C_flag   = c_q;
    assign Z_flag   = z_q;
    assign ram_addr = target;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios plus random stimulus vs a rule-level model.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  rom_data = 8'h00;
    logic        IncPC = 1'b0;
    logic        LoadPC = 1'b0;
    logic        LoadFlags = 1'b0;
    logic        alu_c = 1'b0;
    logic        alu_z = 1'b0;
    logic [11:0] rom_addr;
    logic        Phase;
    logic [3:0]  Instr;
    logic [3:0]  Oprnd;
    logic [11:0] ram_addr;
    logic        C_flag;
    logic        Z_flag;

    always #5 clock = ~clock;

    fetch_sequencer #(
        .PC_WIDTH  (12),
        .ROM_WIDTH (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .rom_data  (rom_data),
        .IncPC     (IncPC),
        .LoadPC    (LoadPC),
        .LoadFlags (LoadFlags),
        .alu_c     (alu_c),
        .alu_z     (alu_z),
        .rom_addr  (rom_addr),
        .Phase     (Phase),
        .Instr     (Instr),
        .Oprnd     (Oprnd),
        .ram_addr  (ram_addr),
        .C_flag    (C_flag),
        .Z_flag    (Z_flag)
    );

    int total = 0;
    int bad = 0;

    // Reference state: what the sequencer should hold after each edge.
    int m_pc = 0, m_ph = 0, m_ins = 0, m_op = 0, m_c = 0, m_z = 0;

    typedef struct {
        int pc; int ph; int ins; int op; int c; int z;
    } exp_t;
    exp_t sb[$];

    int rom_mem [0:4095];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: after each edge the DUT must match the oldest scoreboard entry.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc",       32'(rom_addr), 32'(e.pc));
            chk("phase",    32'(Phase),    32'(e.ph));
            chk("instr",    32'(Instr),    32'(e.ins));
            chk("oprnd",    32'(Oprnd),    32'(e.op));
            chk("c_flag",   32'(C_flag),   32'(e.c));
            chk("z_flag",   32'(Z_flag),   32'(e.z));
            chk("ram_addr", 32'(ram_addr), 32'(e.op * 256 + int'(rom_data)));
        end
    end

    task automatic cycle(input bit rst, input bit en, input int rom, input bit inc,
                         input bit ld, input bit lf, input bit c, input bit z);
        int npc;
        @(negedge clock);
        #1;
        reset_n   = !rst;
        enable    = en;
        rom_data  = 8'(rom);
        IncPC     = inc;
        LoadPC    = ld;
        LoadFlags = lf;
        alu_c     = c;
        alu_z     = z;
        if (rst) begin
            m_pc = 0; m_ph = 0; m_ins = 0; m_op = 0; m_c = 0; m_z = 0;
            #1;
            chk("async_rst_pc",    32'(rom_addr), 32'h0);
            chk("async_rst_phase", 32'(Phase),    32'h0);
            chk("async_rst_flags", 32'({C_flag, Z_flag}), 32'h0);
        end else if (en) begin
            if (ld)       npc = m_op * 256 + rom;
            else if (inc) npc = (m_pc + 1) % 4096;
            else          npc = m_pc;
            if (m_ph == 0) begin
                m_ins = rom / 16;
                m_op  = rom % 16;
            end else if (lf) begin
                m_c = int'(c);
                m_z = int'(z);
            end
            m_ph = 1 - m_ph;
            m_pc = npc;
        end
        sb.push_back('{m_pc, m_ph, m_ins, m_op, m_c, m_z});
    endtask

    // Behavioural decoder: fetch always increments; execute per opcode class.
    task automatic dec_cycle();
        bit inc = 1'b0;
        bit ld = 1'b0;
        if (m_ph == 0) begin
            inc = 1'b1;
        end else begin
            case (m_ins)
                'hC:                    ld = 1'b1;
                'h0:                    begin ld = (m_c != 0); inc = !ld; end
                'h1:                    begin ld = (m_c == 0); inc = !ld; end
                'h8:                    begin ld = (m_z != 0); inc = !ld; end
                'h9:                    begin ld = (m_z == 0); inc = !ld; end
                'h3, 'h6, 'h7, 'hB, 'hF: inc = 1'b1;
                default:                ;
            endcase
        end
        cycle(1'b0, 1'b1, rom_mem[m_pc], inc, ld, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    // Direct check of the state left by the edge following the last driven cycle.
    task automatic expect_state(input string nm, input int pc, input int ph, input int c, input int z);
        @(posedge clock);
        #1;
        chk({nm, "_pc"},    32'(rom_addr), 32'(pc));
        chk({nm, "_phase"}, 32'(Phase),    32'(ph));
        chk({nm, "_flags"}, 32'({C_flag, Z_flag}), 32'(c * 2 + z));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 0;

        // Reset mid-execute with PC=0x123, then first fetch.
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 'hC1, 1, 0, 0, 0, 0);
        cycle(0, 1, 'h22, 0, 1, 0, 0, 0);
        cycle(0, 1, 'h40, 1, 0, 0, 0, 0);
        expect_state("pre_rst", 'h123, 1, 0, 0);
        cycle(1, 1, 'h40, 1, 0, 0, 1, 1);
        cycle(0, 1, 'h4A, 1, 0, 0, 0, 0);
        expect_state("first_fetch", 'h001, 1, 0, 0);
        chk("first_fetch_ir", 32'({Instr, Oprnd}), 32'h4A);

        // JMP 0x345.
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        rom_mem[0] = 'hC3; rom_mem[1] = 'h45;
        dec_cycle(); dec_cycle();
        expect_state("jmp", 'h345, 0, 0, 0);

        // JC not taken with C=0.
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        rom_mem[0] = 'h07; rom_mem[1] = 'h89;
        dec_cycle(); dec_cycle();
        expect_state("jc_not_taken", 'h002, 0, 0, 0);

        // Flags ignored in fetch, captured in execute; then JC taken.
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 'hA0, 1, 0, 1, 1, 1);
        expect_state("flags_fetch", 'h001, 1, 0, 0);
        cycle(0, 1, 'h00, 0, 0, 1, 1, 1);
        expect_state("flags_exec", 'h001, 0, 1, 1);
        rom_mem[1] = 'h07; rom_mem[2] = 'h89;
        dec_cycle(); dec_cycle();
        expect_state("jc_taken", 'h789, 0, 1, 1);

        // Wrap 0xFFF -> 0x000, then load beats increment.
        cycle(0, 1, 'hCF, 1, 0, 0, 0, 0);
        cycle(0, 1, 'hFF, 0, 1, 0, 0, 0);
        expect_state("to_fff", 'hFFF, 0, 1, 1);
        cycle(0, 1, 'h55, 1, 0, 0, 0, 0);
        expect_state("wrap", 'h000, 1, 1, 1);
        cycle(0, 1, 'hA5, 1, 1, 0, 0, 0);
        expect_state("priority", 'h5A5, 0, 1, 1);

        // Enable low freezes everything despite toggling controls.
        cycle(0, 1, 'h3C, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, int'($urandom_range(0, 255)), 1'(i), 1'(i + 1), 1'b1, 1'b0, 1'b0);
        end
        expect_state("frozen", 'h5A6, 1, 1, 1);
        cycle(0, 1, 'h12, 0, 1, 1, 0, 1);
        expect_state("resume", 'hC12, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 64) == 0, ($urandom % 4) != 0, int'($urandom_range(0, 255)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clock);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Supplies the decoder's inputs (Phase, Instr, C_flag, Z_flag) and acts on its PC-control outputs (IncPC, LoadPC, LoadFlags).
- Holds the program counter, the two-phase fetch/execute toggle, the fetched instruction register and the carry/zero flag register.
- Forms the 12-bit jump/RAM address from the operand nibble and the second program byte.
- Sits between the program ROM, the decoder and the ALU in the 4-bit CPU core.

Parameters:
- PC_WIDTH, 12, program-counter and address width; must equal 4 + ROM_WIDTH.
- ROM_WIDTH, 8, program ROM data width: opcode nibble plus operand nibble.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run enable; low freezes all state.
- rom_data  in  8  program ROM read data; combinational read of rom_addr.
- IncPC  in  1  from decoder: increment PC at end of cycle.
- LoadPC  in  1  from decoder: load PC with branch target at end of cycle.
- LoadFlags  in  1  from decoder: capture ALU flags at end of cycle.
- alu_c  in  1  ALU carry out.
- alu_z  in  1  ALU zero out.
- rom_addr  out  12  program ROM address; equals PC.
- Phase  out  1  0 = fetch, 1 = execute.
- Instr  out  4  opcode nibble of the latched instruction.
- Oprnd  out  4  operand/immediate nibble of the latched instruction.
- ram_addr  out  12  {Oprnd, rom_data}; valid in Phase 1.
- C_flag  out  1  registered carry flag.
- Z_flag  out  1  registered zero flag.

Behaviour:
- Reset (asynchronous, any time, including mid-instruction): PC=0, Phase=0, Instr=0, Oprnd=0, C_flag=0, Z_flag=0. The first enabled edge after reset_n rises is a fetch.
- enable=0: PC, Phase, the instruction register and the flags all hold. Outputs stay stable.
- Phase toggles on every enabled edge: 0→1→0 …. Every instruction takes exactly 2 cycles.
- Phase 0 (fetch):
  - At the edge: {Instr, Oprnd} <= rom_data.
  - The decoder asserts IncPC, so PC <= PC+1.
- Phase 1 (execute):
  - rom_data holds the byte at PC, which is the low address byte for two-byte instructions.
  - Branch target = ram_addr = {Oprnd, rom_data}.
  - Two-byte instructions and not-taken branches assert IncPC to skip the address byte.
  - Single-byte instructions (LIT, IN, CMPI, ADDI, NANI, OUT) assert neither IncPC nor LoadPC.
- PC update priority, applied only when enable=1:
  - LoadPC → PC <= {Oprnd, rom_data}.
  - else IncPC → PC <= PC+1 mod 2^12 (0xFFF wraps to 0x000).
  - else hold.
  - Simultaneous LoadPC and IncPC: LoadPC wins.
- Flags: when LoadFlags=1 and enable=1, C_flag <= alu_c and Z_flag <= alu_z. Otherwise they hold.
- Flags are not written in Phase 0 even if LoadFlags is asserted. This guards against decode glitches.
- Instr/Oprnd hold through Phase 1. They change only at the end of a Phase-0 cycle.
- No combinational path from rom_data to Phase, Instr or the flags. ram_addr is combinational from Oprnd and rom_data.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams: JC=0x0, JNC=0x1, CMPI=0x2, CMPM=0x3, LIT=0x4, IN=0x5, LD=0x6, ST=0x7, JZ=0x8, JNZ=0x9, ADDI=0xA, ADDM=0xB, JMP=0xC, OUT=0xD, NANI=0xE, NANDM=0xF.
  - PHASE_FETCH=0 and PHASE_EXEC=1.
  - PC_WIDTH.
- One natural sub-module: pc_counter, the 12-bit register with load/increment priority and async clear.
- Phase toggle, instruction register and flags stay in fetch_sequencer.

Test Plan:
- Reset/fetch: reset_n low mid-Phase-1 with PC=0x123 → PC=0, Phase=0, flags=0 immediately. Then rom_data=0x4A → next edge Instr=0x4, Oprnd=0xA, PC=0x001, Phase=1.
- JMP: ROM[0]=0xC3, ROM[1]=0x45, decoder model connected → after 2 edges PC=0x345, Phase=0.
- Not-taken JC: C_flag=0, ROM[0]=0x07, ROM[1]=0x89 → PC=0x002 after 2 edges. Taken with C_flag=1 → PC=0x789.
- Flags: LoadFlags=1 in Phase 1 with alu_c=1, alu_z=1 → C_flag=Z_flag=1. LoadFlags=1 forced in Phase 0 → flags unchanged.
- Wrap/priority: PC=0xFFF with IncPC → 0x000. IncPC=LoadPC=1 with target 0x5A5 → PC=0x5A5.
- enable=0 for 5 cycles with toggling IncPC/LoadPC/LoadFlags → PC, Phase, Instr and flags unchanged; resumes correctly when enable=1.
